mc_control_unit: RTL and testbench

//  Parametrised multicycle RV32I control unit: main FSM plus ALU-control decode in one block.

---
 rtl/mc_control_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit.sv
// Multicycle RV32I control unit: main FSM and ALU-control decode for the shared-memory datapath.
// Memory states can stall on mem_ready; unknown opcodes park the FSM in a sticky trap state.
module mc_control_unit #(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter bit JUMP_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       mem_ready,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic       iord,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] mem_to_reg,
  output logic [1:0] pc_source,
  output logic [3:0] alu_ctl,
  output logic       illegal,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExecR  = 4'd6,
    StExecI  = 4'd7,
    StRwb    = 4'd8,
    StBr     = 4'd9,
    StJal    = 4'd10,
    StJalr   = 4'd11,
    StLui    = 4'd12,
    StTrap   = 4'd13
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluXor = 4'b0011;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;
  localparam logic [3:0] AluSll = 4'b1000;
  localparam logic [3:0] AluSrl = 4'b1001;
  localparam logic [3:0] AluSra = 4'b1010;

  state_e     state_q, state_d;
  logic       mem_go;
  logic       f7_alt;
  logic       r_f7_ok;
  logic [3:0] alu_func_r, alu_func_i;

  assign mem_go  = mem_ready | ~MEM_WAIT_EN;
  assign f7_alt  = (funct7 == 7'b0100000);
  // R-type only accepts funct7 of 0, or 0100000 for SUB/SRA; anything else falls back to ADD.
  assign r_f7_ok = (funct7 == 7'b0000000) || (f7_alt && (funct3 == 3'b000 || funct3 == 3'b101));

  always_comb begin
    alu_func_i = AluAdd;
    case (funct3)
      3'b000:  alu_func_i = AluAdd;
      3'b111:  alu_func_i = AluAnd;
      3'b110:  alu_func_i = AluOr;
      3'b100:  alu_func_i = AluXor;
      3'b010:  alu_func_i = AluSlt;
      3'b001:  alu_func_i = AluSll;
      3'b101:  alu_func_i = funct7[5] ? AluSra : AluSrl;
      default: alu_func_i = AluAdd;
    endcase
    alu_func_r = alu_func_i;
    if (!r_f7_ok) begin
      alu_func_r = AluAdd;
    end else if (funct3 == 3'b000 && f7_alt) begin
      alu_func_r = AluSub;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    reg_write     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    iord          = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    mem_to_reg    = 2'b00;
    pc_source     = 2'b00;
    alu_ctl       = AluAdd;
    illegal       = 1'b0;

    case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_go;
        pc_write  = mem_go;
        if (mem_go) state_d = StDecode;
      end
      StDecode: begin
        alu_src_b = 2'b10;
        case (opcode)
          OpLoad, OpStore: state_d = StMemAdr;
          OpR:             state_d = StExecR;
          OpI:             state_d = StExecI;
          OpBranch:        state_d = (funct3[2:1] == 2'b00) ? StBr : StTrap;
          OpJal:           state_d = JUMP_EN ? StJal : StTrap;
          OpJalr:          state_d = JUMP_EN ? StJalr : StTrap;
          OpLui:           state_d = JUMP_EN ? StLui : StTrap;
          default:         state_d = StTrap;
        endcase
      end
      StMemAdr: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        state_d   = (opcode == OpStore) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_go) state_d = StMemWb;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        state_d    = StFetch;
      end
      StMemWr: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_go) state_d = StFetch;
      end
      StExecR: begin
        alu_src_a = 2'b01;
        alu_ctl   = alu_func_r;
        state_d   = StRwb;
      end
      StExecI: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        alu_ctl   = alu_func_i;
        state_d   = StRwb;
      end
      StRwb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StBr: begin
        alu_src_a     = 2'b01;
        alu_ctl       = AluSub;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        branch_ne     = funct3[0];
        state_d       = StFetch;
      end
      StJal: begin
        pc_write   = 1'b1;
        pc_source  = 2'b01;
        reg_write  = 1'b1;
        mem_to_reg = 2'b10;
        state_d    = StFetch;
      end
      StJalr: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        mem_to_reg = 2'b10;
        state_d    = StFetch;
      end
      StLui: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b10;
        reg_write  = 1'b1;
        mem_to_reg = 2'b11;
        state_d    = StFetch;
      end
      StTrap: begin
        illegal = 1'b1;
      end
      default: state_d = StTrap;
    endcase

    // Reset wins over any state, including a pending memory wait.
    if (reset) begin
      state_d       = StFetch;
      reg_write     = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed-vector bench for mc_control_unit; a second instance with JUMP_EN=0 checks the jump trap.
module tb_mc_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       mem_ready;

  logic       reg_write, mem_read, mem_write, ir_write, pc_write, pc_write_cond, branch_ne, iord;
  logic [1:0] alu_src_a, alu_src_b, mem_to_reg, pc_source;
  logic [3:0] alu_ctl, state_o;
  logic       illegal;

  logic       reg_write2, mem_read2, mem_write2, ir_write2, pc_write2, pc_write_cond2;
  logic       branch_ne2, iord2, illegal2;
  logic [1:0] alu_src_a2, alu_src_b2, mem_to_reg2, pc_source2;
  logic [3:0] alu_ctl2, state_o2;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [3:0] SFetch = 4'd0,  SDecode = 4'd1, SMemAdr = 4'd2, SMemRd = 4'd3;
  localparam logic [3:0] SMemWb = 4'd4,  SMemWr  = 4'd5, SExecR  = 4'd6, SExecI = 4'd7;
  localparam logic [3:0] SRwb   = 4'd8,  SBr     = 4'd9, SJal    = 4'd10, SJalr = 4'd11;
  localparam logic [3:0] SLui   = 4'd12, STrap   = 4'd13;

  mc_control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .mem_ready(mem_ready), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .branch_ne(branch_ne), .iord(iord), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .mem_to_reg(mem_to_reg), .pc_source(pc_source), .alu_ctl(alu_ctl), .illegal(illegal),
    .state_o(state_o)
  );

  mc_control_unit #(.MEM_WAIT_EN(1'b1), .JUMP_EN(1'b0)) dut_nojump (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .mem_ready(mem_ready), .reg_write(reg_write2), .mem_read(mem_read2),
    .mem_write(mem_write2), .ir_write(ir_write2), .pc_write(pc_write2),
    .pc_write_cond(pc_write_cond2), .branch_ne(branch_ne2), .iord(iord2),
    .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2), .mem_to_reg(mem_to_reg2),
    .pc_source(pc_source2), .alu_ctl(alu_ctl2), .illegal(illegal2), .state_o(state_o2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {reg_write, mem_write, ir_write, pc_write, pc_write_cond}
  function automatic logic [4:0] enables();
    return {reg_write, mem_write, ir_write, pc_write, pc_write_cond};
  endfunction

  // Drive an instruction, pass FETCH and DECODE with memory ready, land in the execute state.
  task automatic issue(input string tag, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7);
    opcode = op; funct3 = f3; funct7 = f7; mem_ready = 1'b1;
    #1;
    check({tag, " fetch"}, state_o, SFetch);
    tick();
    check({tag, " decode"}, state_o, SDecode);
    check({tag, " decode srcb"}, alu_src_b, 2'b10);
    tick();
  endtask

  initial begin
    reset = 1'b1; opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0; mem_ready = 1'b1;
    tick(); tick();
    check("reset state", state_o, SFetch);
    check("reset enables", enables(), 5'b00000);

    // ADD
    reset = 1'b0;
    opcode = 7'b0110011; #1;
    check("add fetch en", {mem_read, ir_write, pc_write, alu_src_b}, {3'b111, 2'b01});
    issue("add", 7'b0110011, 3'b000, 7'b0000000);
    check("add exec", {state_o, alu_ctl, alu_src_a, alu_src_b}, {SExecR, 4'b0010, 2'b01, 2'b00});
    tick();
    check("add rwb", {state_o, reg_write, mem_to_reg}, {SRwb, 1'b1, 2'b00});
    tick();
    check("add back", state_o, SFetch);

    // LW with one wait cycle in FETCH and in MEMRD: 7 cycles
    opcode = 7'b0000011; funct3 = 3'b010; mem_ready = 1'b0; #1;
    check("lw fetch wait", {state_o, ir_write, pc_write, mem_read}, {SFetch, 3'b001});
    tick();
    mem_ready = 1'b1; #1;
    check("lw fetch ready", {state_o, ir_write, pc_write}, {SFetch, 2'b11});
    tick();
    check("lw decode", state_o, SDecode);
    tick();
    check("lw memadr", {state_o, alu_src_a, alu_src_b}, {SMemAdr, 2'b01, 2'b10});
    tick();
    mem_ready = 1'b0; #1;
    check("lw memrd wait", {state_o, mem_read, iord}, {SMemRd, 2'b11});
    tick();
    mem_ready = 1'b1; #1;
    check("lw memrd ready", state_o, SMemRd);
    tick();
    check("lw memwb", {state_o, reg_write, mem_to_reg}, {SMemWb, 1'b1, 2'b01});
    tick();
    check("lw back", state_o, SFetch);

    // BNE / BEQ
    issue("bne", 7'b1100011, 3'b001, 7'd0);
    check("bne br", {state_o, pc_write_cond, branch_ne, alu_ctl, pc_source},
          {SBr, 2'b11, 4'b0110, 2'b01});
    tick();
    issue("beq", 7'b1100011, 3'b000, 7'd0);
    check("beq br", {state_o, pc_write_cond, branch_ne}, {SBr, 2'b10});
    tick();

    // SW, no waits
    issue("sw", 7'b0100011, 3'b010, 7'd0);
    check("sw memadr", state_o, SMemAdr);
    tick();
    check("sw memwr", {state_o, mem_write, iord, branch_ne}, {SMemWr, 3'b110});
    tick();
    check("sw back", state_o, SFetch);

    // I-type and R-type ALU decode
    issue("srai", 7'b0010011, 3'b101, 7'b0100000);
    check("srai alu", {state_o, alu_ctl, alu_src_b}, {SExecI, 4'b1010, 2'b10});
    tick(); tick();
    issue("addi", 7'b0010011, 3'b000, 7'b0100000);
    check("addi alu", {state_o, alu_ctl}, {SExecI, 4'b0010});
    tick(); tick();
    issue("sub", 7'b0110011, 3'b000, 7'b0100000);
    check("sub alu", alu_ctl, 4'b0110);
    tick(); tick();
    issue("xor", 7'b0110011, 3'b100, 7'b0000000);
    check("xor alu", alu_ctl, 4'b0011);
    tick(); tick();
    issue("mul", 7'b0110011, 3'b000, 7'b0000001);
    check("badf7 alu", {alu_ctl, illegal}, {4'b0010, 1'b0});
    tick(); tick();

    // JAL; the JUMP_EN=0 instance traps instead
    issue("jal", 7'b1101111, 3'b000, 7'd0);
    check("jal", {state_o, pc_write, pc_source, reg_write, mem_to_reg},
          {SJal, 1'b1, 2'b01, 1'b1, 2'b10});
    check("nojump trap", {state_o2, illegal2}, {STrap, 1'b1});
    tick();
    issue("jalr", 7'b1100111, 3'b000, 7'd0);
    check("jalr", {state_o, pc_write, pc_source, mem_to_reg, alu_src_a},
          {SJalr, 1'b1, 2'b00, 2'b10, 2'b01});
    tick();
    issue("lui", 7'b0110111, 3'b000, 7'd0);
    check("lui", {state_o, reg_write, mem_to_reg, alu_src_a}, {SLui, 1'b1, 2'b11, 2'b10});
    tick();
    check("nojump sticky", state_o2, STrap);

    // Illegal opcode: sticky trap
    issue("op0", 7'b0000000, 3'b000, 7'd0);
    for (int i = 0; i < 10; i++) begin
      check("trap hold", {state_o, illegal, enables()}, {STrap, 1'b1, 5'b00000});
      tick();
    end
    reset = 1'b1; tick(); reset = 1'b0;
    check("trap cleared", {state_o, illegal}, {SFetch, 1'b0});

    // Bad branch funct3 traps
    issue("blt", 7'b1100011, 3'b100, 7'd0);
    check("blt trap", state_o, STrap);
    reset = 1'b1; tick(); reset = 1'b0;

    // Reset during a MEMWR wait
    issue("swr", 7'b0100011, 3'b010, 7'd0);
    tick();
    mem_ready = 1'b0; #1;
    check("swr wait1", {state_o, mem_write}, {SMemWr, 1'b1});
    tick();
    check("swr wait2", {state_o, mem_write}, {SMemWr, 1'b1});
    reset = 1'b1; #1;
    check("swr reset en", enables(), 5'b00000);
    tick();
    check("swr reset state", {state_o, mem_write}, {SFetch, 1'b0});
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
